// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT output side:
// frame geometry, default sample width, unloader state encoding and
// the base-4 digit-reversal index mapping.
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_LOG4N  = 2;
    localparam int FFT_DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fft_state_e;

    // Swap the two base-4 digits of a 4-bit bin index. A radix-4 DIF
    // pipeline leaves bin {d1,d0} in slot {d0,d1}, so the mapping is its
    // own inverse.
    function automatic logic [3:0] digit_reverse(input logic [3:0] idx);
        return {idx[1:0], idx[3:2]};
    endfunction

endpackage

// File: rtl/fft16_frame_buffer.sv
// 16-entry complex register bank. All slots load in parallel on wr_en;
// a single combinational read port selects one slot for the stream.
module fft16_frame_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [FFT_N*DATA_W-1:0]   wr_re,
    input  logic [FFT_N*DATA_W-1:0]   wr_im,
    input  logic [3:0]                rd_slot,
    output logic [DATA_W-1:0]         rd_re,
    output logic [DATA_W-1:0]         rd_im
);

    logic [DATA_W-1:0] re_q [FFT_N];
    logic [DATA_W-1:0] im_q [FFT_N];
    logic [DATA_W-1:0] re_d [FFT_N];
    logic [DATA_W-1:0] im_d [FFT_N];

    // Next bank contents: whole-frame load or hold.
    always_comb begin
        for (int k = 0; k < FFT_N; k++) begin
            re_d[k] = re_q[k];
            im_d[k] = im_q[k];
        end
        if (wr_en) begin
            for (int k = 0; k < FFT_N; k++) begin
                re_d[k] = wr_re[k*DATA_W +: DATA_W];
                im_d[k] = wr_im[k*DATA_W +: DATA_W];
            end
        end else begin
            for (int k = 0; k < FFT_N; k++) begin
                re_d[k] = re_q[k];
                im_d[k] = im_q[k];
            end
        end
    end

    // Bank storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FFT_N; k++) begin
                re_q[k] <= {DATA_W{1'b0}};
                im_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < FFT_N; k++) begin
                re_q[k] <= re_d[k];
                im_q[k] <= im_d[k];
            end
        end
    end

    // Read port: pure mux off registered storage, so the output only
    // moves when the slot or the bank changes.
    always_comb begin
        rd_re = re_q[rd_slot];
        rd_im = im_q[rd_slot];
    end

endmodule

// File: rtl/fft16_result_unloader.sv
// Takes one parallel 16-point complex FFT result frame and streams it out
// one sample per beat in natural bin order. The frame buffer sits in a
// sub-module; the handshake FSM and beat counter live here.
module fft16_result_unloader
    import fft_pkg::*;
#(
    parameter int DATA_W        = FFT_DATA_W,
    parameter int DIGIT_REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re_0,
    input  logic [DATA_W-1:0] in_re_1,
    input  logic [DATA_W-1:0] in_re_2,
    input  logic [DATA_W-1:0] in_re_3,
    input  logic [DATA_W-1:0] in_re_4,
    input  logic [DATA_W-1:0] in_re_5,
    input  logic [DATA_W-1:0] in_re_6,
    input  logic [DATA_W-1:0] in_re_7,
    input  logic [DATA_W-1:0] in_re_8,
    input  logic [DATA_W-1:0] in_re_9,
    input  logic [DATA_W-1:0] in_re_10,
    input  logic [DATA_W-1:0] in_re_11,
    input  logic [DATA_W-1:0] in_re_12,
    input  logic [DATA_W-1:0] in_re_13,
    input  logic [DATA_W-1:0] in_re_14,
    input  logic [DATA_W-1:0] in_re_15,
    input  logic [DATA_W-1:0] in_im_0,
    input  logic [DATA_W-1:0] in_im_1,
    input  logic [DATA_W-1:0] in_im_2,
    input  logic [DATA_W-1:0] in_im_3,
    input  logic [DATA_W-1:0] in_im_4,
    input  logic [DATA_W-1:0] in_im_5,
    input  logic [DATA_W-1:0] in_im_6,
    input  logic [DATA_W-1:0] in_im_7,
    input  logic [DATA_W-1:0] in_im_8,
    input  logic [DATA_W-1:0] in_im_9,
    input  logic [DATA_W-1:0] in_im_10,
    input  logic [DATA_W-1:0] in_im_11,
    input  logic [DATA_W-1:0] in_im_12,
    input  logic [DATA_W-1:0] in_im_13,
    input  logic [DATA_W-1:0] in_im_14,
    input  logic [DATA_W-1:0] in_im_15,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [3:0]        out_index,
    output logic              out_last
);

    fft_state_e state_q;
    fft_state_e state_d;
    logic [3:0] idx_q;
    logic [3:0] idx_d;

    logic                    out_valid_s;
    logic                    out_last_s;
    logic                    in_ready_s;
    logic                    capture_s;
    logic [3:0]              rd_slot_s;
    logic [FFT_N*DATA_W-1:0] wr_re_s;
    logic [FFT_N*DATA_W-1:0] wr_im_s;
    logic [DATA_W-1:0]       rd_re_s;
    logic [DATA_W-1:0]       rd_im_s;

    // Slot 0 in the low bits so slot k sits at [k*DATA_W +: DATA_W].
    assign wr_re_s = {in_re_15, in_re_14, in_re_13, in_re_12,
                      in_re_11, in_re_10, in_re_9,  in_re_8,
                      in_re_7,  in_re_6,  in_re_5,  in_re_4,
                      in_re_3,  in_re_2,  in_re_1,  in_re_0};
    assign wr_im_s = {in_im_15, in_im_14, in_im_13, in_im_12,
                      in_im_11, in_im_10, in_im_9,  in_im_8,
                      in_im_7,  in_im_6,  in_im_5,  in_im_4,
                      in_im_3,  in_im_2,  in_im_1,  in_im_0};

    // Handshake flags and next state/index. in_ready also opens on the
    // accepted last beat so a waiting frame loads with no idle cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_s = (state_q == STREAM);
        out_last_s  = out_valid_s && (idx_q == 4'd15);
        in_ready_s  = (state_q == IDLE) || (out_valid_s && out_ready && out_last_s);
        capture_s   = in_valid && in_ready_s;
        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    state_d = STREAM;
                    idx_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end
            end
            STREAM: begin
                if (capture_s) begin
                    state_d = STREAM;
                    idx_d   = 4'd0;
                end else if (out_ready && out_last_s) begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end else if (out_ready) begin
                    idx_d   = idx_q + 4'd1;
                end else begin
                    idx_d   = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // State and beat counter; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Map the natural bin index onto the buffer slot holding that bin.
    always_comb begin
        if (DIGIT_REVERSE != 0) begin
            rd_slot_s = digit_reverse(idx_q);
        end else begin
            rd_slot_s = idx_q;
        end
    end

    fft16_frame_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture_s),
        .wr_re   (wr_re_s),
        .wr_im   (wr_im_s),
        .rd_slot (rd_slot_s),
        .rd_re   (rd_re_s),
        .rd_im   (rd_im_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_last  = out_last_s;
    assign out_index = idx_q;
    assign out_re    = rd_re_s;
    assign out_im    = rd_im_s;

endmodule

// File: doc/fft16_result_unloader.md
Name: fft16_result_unloader

Overview:
- Output-side counterpart of the parallel radix-4 butterfly datapath.
- Accepts one 16-point complex result frame as a parallel word set, under a valid/ready handshake.
- Streams the frame out one complex sample per beat, in natural frequency order, with radix-4 digit-reversal undone.
- Sits between the last butterfly stage and any serial consumer (DMA, magnitude unit, output FIFO).

Parameters:
- DATA_W, 16, width of each real/imag component (two's complement, passed through unmodified)
- DIGIT_REVERSE, 1, 1 = reorder base-4 digit-reversed input slots to natural order; 0 = stream slots in index order

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  parallel frame present on in_re_*/in_im_*
- in_ready  output  1  unloader can capture a frame this cycle
- in_re_0 .. in_re_15  input  DATA_W each  real parts of frame slots 0..15
- in_im_0 .. in_im_15  input  DATA_W each  imaginary parts of frame slots 0..15
- out_valid  output  1  out_re/out_im/out_index hold a valid sample
- out_ready  input  1  downstream accepts the current sample
- out_re  output  DATA_W  real part of current sample
- out_im  output  DATA_W  imaginary part of current sample
- out_index  output  4  natural-order bin number of current sample
- out_last  output  1  high with out_valid when out_index == 15

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; frame buffer cleared to 0; idx = 0.
  - out_valid = 0, out_last = 0, out_index = 0, out_re = out_im = 0.
  - in_ready = 1 in the first cycle after release.
- States:
  - IDLE: buffer empty.
  - STREAM: buffer full, sample idx being presented.
- in_ready = (state == IDLE) OR (out_valid AND out_ready AND out_last). This is combinational, so back-to-back frames run with zero bubble.
- Capture: on a rising edge with in_valid AND in_ready:
  - all 32 components are registered into the buffer;
  - idx <= 0; state <= STREAM.
- Latency: out_valid rises in the cycle after capture, presenting out_index 0.
- Output data: out_re/out_im = buffer[slot(idx)], a mux off registered storage.
  - DIGIT_REVERSE = 1: slot = {idx[1:0], idx[3:2]}.
  - DIGIT_REVERSE = 0: slot = idx.
- out_index = idx; out_valid = (state == STREAM); out_last = out_valid AND (idx == 15).
- Advance: on out_valid AND out_ready with idx < 15, idx <= idx + 1.
- Stall: out_ready low holds idx, data and out_valid stable, with no glitch on data.
- Last beat accepted:
  - if in_valid is also high in that cycle, capture the new frame, idx <= 0, and stay in STREAM;
  - otherwise state <= IDLE, idx <= 0.
- in_valid while in STREAM (not on the last beat) is ignored. in_ready = 0, and the buffer is unchanged.
- idx never wraps except through frame completion.
- Reset asserted mid-frame: the frame is discarded immediately. out_valid drops asynchronously and no partial stream resumes.
- No arithmetic is performed. Widths are preserved bit-exact, with no scaling or saturation.

Decomposition:
- Shared package (fft_pkg):
  - FFT_N = 16, FFT_LOG4N = 2, DATA_W default;
  - digit-reverse function mapping a 4-bit index to a 4-bit slot;
  - state enum {IDLE, STREAM}.
- One natural sub-module, fft16_frame_buffer: 16-entry complex register bank with parallel write and one indexed read port.
- The handshake FSM and counter stay in the top.

Test Plan:
- Single frame, digit-reversed order:
  - Stimulus: load in_re_k = k, in_im_k = 100 + k, with out_ready held high.
  - Expected out_re sequence: 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; im is the same +100.
  - out_last is high only on beat 16. in_ready returns high with that beat.
- DIGIT_REVERSE = 0, same frame -> out_re = 0..15 in order; out_index = 0..15.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... with an LFSR.
  - Required: each sample appears exactly once; data/index stay stable during stall cycles; 16 accepted beats total.
- Back-to-back frames:
  - Stimulus: frame A (re = 0x1000 + k), then frame B (re = 0x2000 + k) presented with in_valid held high.
  - Required: B is captured on A's last accepted beat; B index 0 appears in the next cycle; no idle bubble.
- Ignored load:
  - Stimulus: assert in_valid with re = 0x7FFF at beat 5 of a frame.
  - Required: in_ready = 0; the stream continues with the original values.
- Reset mid-stream:
  - Stimulus: drop rst_n at beat 7.
  - Required: out_valid = 0 immediately; after release in_ready = 1; the next frame starts at index 0 with correct data.
- Negative values:
  - Stimulus: a frame with re = -32768, im = -1 in all slots.
  - Required: values are passed through bit-exact (0x8000, 0xFFFF).
